if_id_reg: RTL and testbench

- Pipeline register between the IFU (fetch) and decode stage.
- Latches the fetch PC, the fetched instruction, the fetch exception code and the branch-delay flag, and adds a valid bit.
- Supports stall (hold), flush (bubble) and exception/interrupt redirect (handler bubble).
- Precomputes the link address PC+8 for jal/jalr in decode.

---
 rtl/if_id_reg_pkg.sv | 32 +++
 rtl/if_id_reg_if.sv | 48 ++++
 rtl/if_id_reg_perf_sat_counter.sv | 35 +++
 rtl/if_id_reg.sv | 79 +++++++
 tb/tb_if_id_reg.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/if_id_reg_pkg.sv
// IF/ID pipeline register shared definitions: exception codes, reset/handler PCs, stage record.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a. Optional IF_ID_PERF_CNT_EN build adds stall/bubble counters to the register.
package if_id_reg_pkg;

  // Exception codes carried alongside each fetched instruction
  localparam logic [5:0] EXC_NONE = 6'd0;
  localparam logic [5:0] EXC_INT  = 6'd0;
  localparam logic [5:0] EXC_ADEL = 6'd4;
  localparam logic [5:0] EXC_RI   = 6'd10;

  // PC after reset, PC loaded on an exception/interrupt redirect, bubble instruction word
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  // Everything held for one decode-stage slot
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  exc;
    logic        bd;
    logic        valid;
  } id_stage_t;

  // Return address written by jal/jalr: skips the branch and its delay slot.
  // Plain 32-bit add, so the carry out is dropped and the result wraps.
  function automatic logic [31:0] link_addr(input logic [31:0] pc);
    return pc + 32'd8;
  endfunction

endpackage

// File: rtl/if_id_reg_if.sv
// Fetch-to-decode bundle: control (EN/flush/req), fetch-side *_F fields and decode-side *_D fields.
// Latency: n/a (wiring only); the register that uses it adds exactly one cycle.
// Backpressure: EN = 0 stalls the consumer; req/flush override the stall. IF_ID_PERF_CNT_EN adds counters.
interface if_id_reg_if;

  // Control from the hazard unit and CP0
  logic        EN;
  logic        flush;
  logic        req;

  // Fetch stage
  logic [31:0] PC_F;
  logic [31:0] instr_F;
  logic [5:0]  ExcCode_F;
  logic        BD_F;

  // Decode stage
  logic [31:0] PC_D;
  logic [31:0] instr_D;
  logic [31:0] PC8_D;
  logic [5:0]  ExcCode_D;
  logic        BD_D;
  logic        valid_D;

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
`endif

  // Pipeline control and fetch side: drives the register
  modport master (
    output EN, flush, req, PC_F, instr_F, ExcCode_F, BD_F,
`ifdef IF_ID_PERF_CNT_EN
    input  stall_cnt, bubble_cnt,
`endif
    input  PC_D, instr_D, PC8_D, ExcCode_D, BD_D, valid_D
  );

  // The IF/ID register itself
  modport slave (
    input  EN, flush, req, PC_F, instr_F, ExcCode_F, BD_F,
`ifdef IF_ID_PERF_CNT_EN
    output stall_cnt, bubble_cnt,
`endif
    output PC_D, instr_D, PC8_D, ExcCode_D, BD_D, valid_D
  );

endinterface

// File: rtl/if_id_reg_perf_sat_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping; only built with IF_ID_PERF_CNT_EN.
// Latency: count visible one cycle after the enabling edge.
// Backpressure: none; en_i is sampled every cycle.
`ifdef IF_ID_PERF_CNT_EN
module perf_sat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Count enabled events, stop once every bit is set
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Counter state, cleared by the asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: latches fetch PC/instr/exception/delay-slot flag, adds valid, precomputes PC+8.
// Latency: one cycle from *_F to *_D; outputs come only from flops (PC8_D is an adder on the PC flop).
// Backpressure: EN = 0 holds; flush inserts a bubble at PC_F; req inserts a bubble at HANDLER_PC. IF_ID_PERF_CNT_EN adds counters.
module if_id_reg #(
  parameter logic [31:0] RESET_PC   = if_id_reg_pkg::RESET_PC,
  parameter logic [31:0] HANDLER_PC = if_id_reg_pkg::HANDLER_PC,
  parameter logic [31:0] NOP        = if_id_reg_pkg::NOP
) (
  input  logic         clk,
  input  logic         reset,
  if_id_reg_if.slave   bus
);

  import if_id_reg_pkg::*;

  id_stage_t stage_q;
  id_stage_t stage_d;

  // Priority req > flush > stall > load. A redirect or flush must never be
  // blocked by a stall, otherwise a wrong-path instruction would survive in decode.
  // A faulting fetch keeps its PC and code (needed for EPC) but its word is
  // replaced by NOP so decode never acts on garbage from a bad address.
  always_comb begin
    stage_d = stage_q;
    if (bus.req) begin
      stage_d = '{pc: HANDLER_PC, instr: NOP, exc: EXC_NONE, bd: 1'b0, valid: 1'b0};
    end else if (bus.flush) begin
      stage_d = '{pc: bus.PC_F, instr: NOP, exc: EXC_NONE, bd: 1'b0, valid: 1'b0};
    end else if (bus.EN) begin
      stage_d.pc    = bus.PC_F;
      stage_d.instr = (bus.ExcCode_F == EXC_NONE) ? bus.instr_F : NOP;
      stage_d.exc   = bus.ExcCode_F;
      stage_d.bd    = bus.BD_F;
      stage_d.valid = 1'b1;
    end
  end

  // Stage register; reset takes effect immediately, without a clock edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q <= '{pc: RESET_PC, instr: NOP, exc: EXC_NONE, bd: 1'b0, valid: 1'b0};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign bus.PC_D      = stage_q.pc;
  assign bus.instr_D   = stage_q.instr;
  assign bus.ExcCode_D = stage_q.exc;
  assign bus.BD_D      = stage_q.bd;
  assign bus.valid_D   = stage_q.valid;
  assign bus.PC8_D     = link_addr(stage_q.pc);

`ifdef IF_ID_PERF_CNT_EN
  logic stall_evt;
  logic bubble_evt;

  // Classify each edge: a stall is a pure hold, a bubble is any flush or redirect
  always_comb begin
    stall_evt  = !bus.EN && !bus.flush && !bus.req;
    bubble_evt = bus.flush || bus.req;
  end

  perf_sat_counter u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (stall_evt),
    .cnt_o (bus.stall_cnt)
  );

  perf_sat_counter u_bubble_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (bubble_evt),
    .cnt_o (bus.bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Directed bench for the IF/ID register: reset, load, stall, fetch fault, flush, redirect, wrap, async reset.
// Latency: checks are sampled 1 time unit after each rising edge.
// Backpressure: stall/flush/redirect driven directly; counter checks built only with IF_ID_PERF_CNT_EN.
module tb_if_id_reg;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  if_id_reg_if bus_if ();

  if_id_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic fl, input logic rq,
                       input logic [31:0] pc, input logic [31:0] ins,
                       input logic [5:0] exc, input logic bd);
    bus_if.EN        = en;
    bus_if.flush     = fl;
    bus_if.req       = rq;
    bus_if.PC_F      = pc;
    bus_if.instr_F   = ins;
    bus_if.ExcCode_F = exc;
    bus_if.BD_F      = bd;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] pc8, input logic [5:0] exc,
                         input logic bd, input logic vld);
    chk({tag, ".PC_D"},      bus_if.PC_D,             pc);
    chk({tag, ".instr_D"},   bus_if.instr_D,          ins);
    chk({tag, ".PC8_D"},     bus_if.PC8_D,            pc8);
    chk({tag, ".ExcCode_D"}, {26'd0, bus_if.ExcCode_D}, {26'd0, exc});
    chk({tag, ".BD_D"},      {31'd0, bus_if.BD_D},      {31'd0, bd});
    chk({tag, ".valid_D"},   {31'd0, bus_if.valid_D},   {31'd0, vld});
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset held for 3 cycles while fetch presents a different PC
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0000_3010, 32'h2402_0001, 6'd0, 1'b1);
    step(); step(); step();
    chk_all("reset", 32'h0000_3000, 32'h0, 32'h0000_3008, 6'd0, 1'b0, 1'b0);

    // Release mid-cycle; the next edge is the first load
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0000_3004, 32'h3c01_1234, 6'd0, 1'b0);
    step();
    chk_all("load", 32'h0000_3004, 32'h3c01_1234, 32'h0000_300C, 6'd0, 1'b0, 1'b1);

    // Stall for two cycles with different fetch data
    drive(1'b0, 1'b0, 1'b0, 32'h0000_3008, 32'h3421_5678, 6'd10, 1'b1);
    step();
    chk_all("stall1", 32'h0000_3004, 32'h3c01_1234, 32'h0000_300C, 6'd0, 1'b0, 1'b1);
    step();
    chk_all("stall2", 32'h0000_3004, 32'h3c01_1234, 32'h0000_300C, 6'd0, 1'b0, 1'b1);

    // Delay-slot instruction load
    drive(1'b1, 1'b0, 1'b0, 32'h0000_3008, 32'h0000_0021, 6'd0, 1'b1);
    step();
    chk_all("bd_load", 32'h0000_3008, 32'h0000_0021, 32'h0000_3010, 6'd0, 1'b1, 1'b1);

    // Misaligned fetch: word squashed, code and PC kept
    drive(1'b1, 1'b0, 1'b0, 32'h0000_3002, 32'hFFFF_FFFF, 6'd4, 1'b0);
    step();
    chk_all("adel", 32'h0000_3002, 32'h0, 32'h0000_300A, 6'd4, 1'b0, 1'b1);

    // Flush wins over stall; BD of the incoming fetch is dropped
    drive(1'b0, 1'b1, 1'b0, 32'h0000_3020, 32'h1234_5678, 6'd0, 1'b1);
    step();
    chk_all("flush", 32'h0000_3020, 32'h0, 32'h0000_3028, 6'd0, 1'b0, 1'b0);

    // Load a faulting RI fetch in a delay slot, then redirect over flush and stall
    drive(1'b1, 1'b0, 1'b0, 32'h0000_3030, 32'hABCD_0000, 6'd10, 1'b1);
    step();
    chk_all("ri", 32'h0000_3030, 32'h0, 32'h0000_3038, 6'd10, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_3040, 32'h1111_1111, 6'd4, 1'b1);
    step();
    chk_all("req", 32'h0000_4180, 32'h0, 32'h0000_4188, 6'd0, 1'b0, 1'b0);

    // PC+8 wraps at the top of the address space
    drive(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0800_0C00, 6'd0, 1'b0);
    step();
    chk_all("wrap", 32'hFFFF_FFFC, 32'h0800_0C00, 32'h0000_0004, 6'd0, 1'b0, 1'b1);

    // Stall, then assert reset between edges: outputs clear with no edge
    drive(1'b0, 1'b0, 1'b0, 32'h0000_3050, 32'h2222_2222, 6'd0, 1'b1);
    step();
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_rst", 32'h0000_3000, 32'h0, 32'h0000_3008, 6'd0, 1'b0, 1'b0);
    step();
    reset = 1'b1;

`ifdef IF_ID_PERF_CNT_EN
    // Counters restart from zero after the reset above: 5 stalls then 2 flushes
    drive(1'b0, 1'b0, 1'b0, 32'h0000_3060, 32'h0, 6'd0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    drive(1'b0, 1'b1, 1'b0, 32'h0000_3064, 32'h0, 6'd0, 1'b0);
    for (int i = 0; i < 2; i++) step();
    chk("stall_cnt", bus_if.stall_cnt, 32'd5);
    chk("bubble_cnt", bus_if.bubble_cnt, 32'd2);

    // Saturation: preload all-ones, one more stall must not wrap
    force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_stall_cnt.cnt_q;
    drive(1'b0, 1'b0, 1'b0, 32'h0000_3068, 32'h0, 6'd0, 1'b0);
    step();
    chk("stall_sat", bus_if.stall_cnt, 32'hFFFF_FFFF);
    chk("bubble_hold", bus_if.bubble_cnt, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
